digit_scan_ctrl: RTL and testbench
==================================

# digit_scan_ctrl

- Parametrised time-multiplexed scanner for common-anode seven-segment banks.
- Sequences any number of digit anodes in fixed-length refresh slots and skips masked digits.
- Each slot starts with a dead-time blank for ghost suppression, followed by brightness-scaled (PWM) on-time.
- Sits between the display data path and the board anode pins. Exports the active digit index and a slot-start strobe so the segment mux can load the next digit's pattern during the blank.

## Interface
Parameters:
- NUM_DIGITS, 8, number of anodes (2..16)
- DIV, 100000, clock cycles per digit slot; must be >= DEAD+16
- DEAD, 1000, blank cycles at start of each slot (0 allowed)
- ACTIVE_LOW, 1, 1: anode asserted = 0; 0: asserted = 1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable
- digit_en  in  NUM_DIGITS  per-digit mask, bit i = digit i participates
- brightness  in  4  on-time in 16ths of the post-dead window; 15 = full
- anode  out  NUM_DIGITS  registered one-hot anode drive, polarity per ACTIVE_LOW
- digit_sel  out  clog2(NUM_DIGITS)  index of current slot's digit
- slot_start  out  1  one-cycle strobe, first cycle of every slot

## Operation
- Reset values:
  - anode = all inactive (all 1s when ACTIVE_LOW)
  - digit_sel = 0, slot_start = 0
  - internal slot counter = 0
  - state = IDLE
- States:
  - IDLE: anode inactive, counter held at 0.
  - BLANK: slot counter < DEAD, anode inactive.
  - ON: anode bit digit_sel asserted.
  - OFF: remainder of slot, anode inactive.
- IDLE -> BLANK when en=1 and digit_en != 0.
  - The first digit is the lowest set bit of digit_en.
  - slot_start pulses on entry.
- Slot counter runs 0..DIV-1. At DIV-1:
  - Counter returns to 0.
  - digit_sel moves to the next set bit of digit_en above the current index, wrapping to bit 0 after NUM_DIGITS-1.
  - slot_start pulses; state -> BLANK (or ON if DEAD=0 and on-time > 0).
- A single enabled digit re-selects itself every slot.
- brightness and digit_en are sampled only at slot start and held for the whole slot. Mid-slot changes take effect at the next slot.
- On-window, with STEP = (DIV-DEAD)/16 (integer floor):
  - The window starts at counter = DEAD.
  - It ends before counter = DEAD + brightness*STEP.
  - brightness=15 extends the window to the end of the slot (counter DIV-1 inclusive).
  - brightness=0 produces no ON phase: BLANK -> OFF.
- The product brightness*STEP uses a counter-width+4 bit intermediate; no overflow for DIV <= 2^24.
- Abort conditions (next cycle: IDLE, anode inactive, counter 0, digit_sel holds last value):
  - en falling in any state.
  - digit_en sampled at slot start equal to 0.
- en rising while idle: slot_start on the following cycle.
- Never more than one anode asserted. Anode never asserted during BLANK or IDLE.

## Timing
- slot_start is high in cycle S, where S is the first cycle of a slot.
- digit_sel carries the new value in cycle S and is stable for DIV cycles.
- Anode for digit_sel is asserted in cycles S+DEAD .. S+DEAD+brightness*STEP-1. For brightness=15 this becomes S+DEAD .. S+DIV-1.
- Consecutive slot_start strobes are exactly DIV cycles apart while enabled.
- Start latency: en sampled high at edge t -> slot_start in the cycle following t.
- Stop latency: en sampled low at edge t -> anode inactive from edge t+1.
- Reset is asynchronous: assertion immediately forces all outputs to reset values, mid-slot included. Release is synchronised internally so the first slot starts cleanly.

## Test plan
All scenarios use NUM_DIGITS=4, DIV=20, DEAD=4, ACTIVE_LOW=1, so STEP=1.
- Reset, then en=1, digit_en=4'b1111, brightness=15:
  - digit_sel runs 0,1,2,3,0.
  - slot_start every 20 cycles.
  - anode 4'b1111 for cycles 0..3 of each slot, then 4'b1110/1101/1011/0111 for cycles 4..19.
- digit_en=4'b1010, brightness=8:
  - digit_sel alternates 1,3.
  - anode asserted for cycles 4..11 of each slot only (8 cycles); all 1s otherwise.
- brightness=0:
  - anode constant 4'b1111.
  - slot_start and digit_sel sequencing continue.
- Change brightness 15->2 and digit_en 1111->0001 at slot cycle 10:
  - Current slot is unchanged.
  - Next slot shows digit 0, on cycles 4..5.
  - Following slots stay on digit 0.
- en dropped at slot cycle 7 (anode active):
  - anode = 4'b1111 next cycle; no further slot_start.
  - Re-raise en: slot_start one cycle later on the lowest enabled digit.
- rst_n pulsed low at slot cycle 9:
  - anode = 4'b1111, digit_sel=0, slot_start=0 immediately.
  - After release with en=1, a normal slot begins.
- Over all scenarios, assert that at most one anode bit is ever low.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed anode scanner for common-anode
// seven-segment banks. Each fixed-length slot opens with a dead-time blank,
// followed by a brightness-scaled on-window. Masked digits are skipped.
module digit_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 100000,
    parameter int DEAD       = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic [3:0]                    brightness,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic                          slot_start
);

    localparam int CW = $clog2(DIV);
    localparam int SW = $clog2(NUM_DIGITS);
    // brightness*STEP is formed at counter width + 4 so 15*STEP cannot wrap
    localparam int PW = CW + 4;

    localparam logic [PW-1:0]         STEP    = PW'((DIV - DEAD) / 16);
    localparam logic [PW-1:0]         DEAD_W  = PW'(DEAD);
    localparam logic [CW-1:0]         LAST    = CW'(DIV - 1);
    localparam logic [NUM_DIGITS-1:0] ONE     = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] OFF_PAT = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2,
        S_OFF   = 2'd3
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [3:0]      bright_reg;
    logic [1:0]      rst_sync_reg;
    logic            run_ok;

    logic [SW-1:0]   nxt_idx;
    logic [SW-1:0]   cand;
    logic            nxt_found;
    int              base;

    logic            start_slot;
    logic            stop;
    logic [CW-1:0]   cnt_nxt;
    logic [3:0]      bright_nxt;
    logic [SW-1:0]   sel_nxt;
    logic [PW-1:0]   limit;
    logic            on_nxt;
    logic [NUM_DIGITS-1:0] onehot;
    logic [NUM_DIGITS-1:0] on_pat;

    // Reset release is re-timed so the scanner never starts on a partial edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign run_ok = rst_sync_reg[1];

    // Find the next enabled digit above the current one, wrapping; from idle
    // the search starts above the top index so it lands on the lowest set bit
    always_comb begin
        nxt_idx   = digit_sel;
        nxt_found = 1'b0;
        cand      = '0;
        base      = (state_reg == S_IDLE) ? (NUM_DIGITS - 1) : int'(digit_sel);
        for (int i = 1; i <= NUM_DIGITS; i++) begin
            cand = SW'((base + i) % NUM_DIGITS);
            if (!nxt_found && digit_en[cand]) begin
                nxt_found = 1'b1;
                nxt_idx   = cand;
            end
        end
    end

    // Decide slot boundaries, aborts and the anode value for the next cycle
    always_comb begin
        start_slot = 1'b0;
        stop       = 1'b0;
        cnt_nxt    = cnt_reg + CW'(1);
        bright_nxt = bright_reg;
        sel_nxt    = digit_sel;
        if (!run_ok || !en) begin
            stop = 1'b1;
        end else if (state_reg == S_IDLE || cnt_reg == LAST) begin
            // mask and brightness are only looked at here, at the slot boundary
            if (|digit_en) begin
                start_slot = 1'b1;
            end else begin
                stop = 1'b1;
            end
        end
        if (start_slot) begin
            cnt_nxt    = '0;
            bright_nxt = brightness;
            sel_nxt    = nxt_idx;
        end
        limit  = DEAD_W + PW'(bright_nxt) * STEP;
        on_nxt = !stop && (PW'(cnt_nxt) >= DEAD_W) &&
                 ((bright_nxt == 4'd15) || (PW'(cnt_nxt) < limit));
        onehot = ONE << sel_nxt;
        on_pat = (ACTIVE_LOW != 0) ? ~onehot : onehot;
    end

    // Scan FSM with registered anode, digit index and slot strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            bright_reg <= '0;
            digit_sel  <= '0;
            slot_start <= 1'b0;
            anode      <= OFF_PAT;
        end else begin
            slot_start <= start_slot;
            digit_sel  <= sel_nxt;
            bright_reg <= bright_nxt;
            if (stop) begin
                state_reg <= S_IDLE;
                cnt_reg   <= '0;
                anode     <= OFF_PAT;
            end else begin
                cnt_reg <= cnt_nxt;
                anode   <= on_nxt ? on_pat : OFF_PAT;
                if (on_nxt) begin
                    state_reg <= S_ON;
                end else if (PW'(cnt_nxt) < DEAD_W) begin
                    state_reg <= S_BLANK;
                end else begin
                    state_reg <= S_OFF;
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed scenarios for digit_scan_ctrl with a
// per-cycle expected-output scoreboard (NUM_DIGITS=4, DIV=20, DEAD=4).
module tb_digit_scan_ctrl;

    localparam int N    = 4;
    localparam int DIV  = 20;
    localparam int DEAD = 4;
    localparam int STEP = (DIV - DEAD) / 16;

    typedef struct packed {
        logic [3:0] anode;
        logic [1:0] sel;
        logic       start;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] digit_en;
    logic [3:0] brightness;
    logic [3:0] anode;
    logic [1:0] digit_sel;
    logic       slot_start;

    exp_t exp_q[$];
    int   total_count;
    int   pass_count;

    digit_scan_ctrl #(
        .NUM_DIGITS(N),
        .DIV(DIV),
        .DEAD(DEAD),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .digit_en(digit_en),
        .brightness(brightness),
        .anode(anode),
        .digit_sel(digit_sel),
        .slot_start(slot_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_count++;
        assert (obs === expv) pass_count++;
        else $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, expv, $time);
    endtask

    // Expected outputs for slot cycles first..last of a slot on digit sel
    task automatic push_slot(input int sel, input int br, input int first, input int last);
        exp_t e;
        for (int c = first; c <= last; c++) begin
            e.sel   = 2'(sel);
            e.start = (c == 0);
            if (c >= DEAD && (br == 15 || c < DEAD + br * STEP))
                e.anode = ~(4'b0001 << sel);
            else
                e.anode = 4'b1111;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle(input int sel, input int n);
        exp_t e;
        e.anode = 4'b1111;
        e.sel   = 2'(sel);
        e.start = 1'b0;
        for (int k = 0; k < n; k++) exp_q.push_back(e);
    endtask

    // Advance n cycles, comparing DUT outputs with the scoreboard 1ns after each edge
    task automatic run(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("anode", 32'(anode), 32'(e.anode));
                chk("digit_sel", 32'(digit_sel), 32'(e.sel));
                chk("slot_start", 32'(slot_start), 32'(e.start));
                chk("onehot", 32'($countones(~anode) <= 1), 32'd1);
                if (slot_start === 1'b1)
                    $display("slot_start t=%0t digit_sel=%0d", $time, digit_sel);
            end
        end
    endtask

    initial begin
        total_count = 0;
        pass_count  = 0;
        rst_n       = 1'b1;
        en          = 1'b0;
        digit_en    = 4'b0000;
        brightness  = 4'd0;

        // reset values
        #1 rst_n = 1'b0;
        #2;
        chk("reset_anode", 32'(anode), 32'hF);
        chk("reset_digit_sel", 32'(digit_sel), 32'd0);
        chk("reset_slot_start", 32'(slot_start), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_idle(0, 3);
        run(3);

        // full brightness, all digits: 0,1,2,3,0
        en = 1'b1; digit_en = 4'b1111; brightness = 4'd15;
        push_slot(0, 15, 0, 19);
        push_slot(1, 15, 0, 19);
        push_slot(2, 15, 0, 19);
        push_slot(3, 15, 0, 19);
        push_slot(0, 15, 0, 19);
        run(100);

        // sparse mask 1010, brightness 8: digits 1,3 alternate
        digit_en = 4'b1010; brightness = 4'd8;
        push_slot(1, 8, 0, 19);
        push_slot(3, 8, 0, 19);
        push_slot(1, 8, 0, 19);
        push_slot(3, 8, 0, 19);
        run(80);

        // brightness 0: anodes stay dark, sequencing continues
        digit_en = 4'b1111; brightness = 4'd0;
        push_slot(0, 0, 0, 19);
        push_slot(1, 0, 0, 19);
        push_slot(2, 0, 0, 19);
        run(60);

        // mid-slot change at slot cycle 10 only affects the following slots
        brightness = 4'd15;
        push_slot(3, 15, 0, 19);
        run(11);
        brightness = 4'd2; digit_en = 4'b0001;
        push_slot(0, 2, 0, 19);
        push_slot(0, 2, 0, 19);
        push_slot(0, 2, 0, 19);
        run(69);

        // en dropped at slot cycle 7 while the anode is on, then re-raised
        brightness = 4'd15; digit_en = 4'b0110;
        push_slot(1, 15, 0, 7);
        run(8);
        en = 1'b0;
        push_idle(1, 5);
        run(5);
        en = 1'b1;
        push_slot(1, 15, 0, 19);
        push_slot(2, 15, 0, 9);
        run(30);

        // asynchronous reset at slot cycle 9
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("async_rst_anode", 32'(anode), 32'hF);
        chk("async_rst_digit_sel", 32'(digit_sel), 32'd0);
        chk("async_rst_slot_start", 32'(slot_start), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        digit_en = 4'b1111; brightness = 4'd15;
        push_idle(0, 3);
        run(3);
        en = 1'b1;
        push_slot(0, 15, 0, 19);
        push_slot(1, 15, 0, 19);
        run(40);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
